// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/stall sequencer driving pipeline register loads, flushes, bubbles and perf counters
// Ports: clk, reset (async active-low); icache_read/icache_resp, dcache_req/dcache_resp cache handshakes;
//        br_taken (EX taken branch); ex_is_load/ex_rd/id_rs1/id_rs2 load-use detection;
//        load_pc/load_if_id/load_back load enables; flush_if_id/bubble_id_ex squash controls;
//        stall_cnt/flush_cnt/bubble_cnt wrapping event counters.
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             icache_read,
  input  logic             icache_resp,
  input  logic             dcache_req,
  input  logic             dcache_resp,
  input  logic             br_taken,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_back,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);
  typedef enum logic {RUN, MEM_STALL} state_t;
  state_t state_q, state_d;
  logic i_done_q, i_done_d, d_done_q, d_done_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, bubble_cnt_q, bubble_cnt_d;
  logic i_ok, d_ok, advance, load_use, flush, bubble, stalled;
  always_comb begin
    // done flags only carry meaning across a stall; in RUN they are always clear
    i_ok = !icache_read | icache_resp | (state_q == MEM_STALL & i_done_q);
    d_ok = !dcache_req | dcache_resp | (state_q == MEM_STALL & d_done_q);
    advance = i_ok & d_ok;
    stalled = !advance;
    load_use = ex_is_load & (ex_rd != 5'd0) & (ex_rd == id_rs1 | ex_rd == id_rs2);
    flush = advance & br_taken;
    bubble = advance & !br_taken & load_use;
    load_pc = advance & !bubble;
    load_if_id = advance & !bubble;
    load_back = advance;
    flush_if_id = flush;
    bubble_id_ex = bubble;
    state_d = advance ? RUN : MEM_STALL;
    // responses are only captured while their request is up, so stray pulses are dropped
    i_done_d = advance ? 1'b0 : (i_ok & icache_read) | (state_q == MEM_STALL & i_done_q);
    d_done_d = advance ? 1'b0 : (d_ok & dcache_req) | (state_q == MEM_STALL & d_done_q);
    stall_cnt_d = stall_cnt_q + CNT_W'(stalled);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush);
    bubble_cnt_d = bubble_cnt_q + CNT_W'(bubble);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic icache_read = 0, icache_resp = 0, dcache_req = 0, dcache_resp = 0, br_taken = 0, ex_is_load = 0;
  logic [4:0] ex_rd = 0, id_rs1 = 0, id_rs2 = 0;
  logic load_pc, load_if_id, load_back, flush_if_id, bubble_id_ex;
  logic [31:0] stall_cnt, flush_cnt, bubble_cnt;
  int n_cmp = 0, n_err = 0;
  pipeline_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .icache_read(icache_read), .icache_resp(icache_resp),
    .dcache_req(dcache_req), .dcache_resp(dcache_resp),
    .br_taken(br_taken), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_back(load_back),
    .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
  );
  always #5 clk = ~clk;
  wire [4:0] ctl = {load_pc, load_if_id, load_back, flush_if_id, bubble_id_ex};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic ir, irsp, dq, drsp, br, ld, input logic [4:0] rd, rs1, rs2);
    @(posedge clk);
    #1;
    {icache_read, icache_resp, dcache_req, dcache_resp, br_taken, ex_is_load} = {ir, irsp, dq, drsp, br, ld};
    {ex_rd, id_rs1, id_rs2} = {rd, rs1, rs2};
    #1;
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic cnts(input string tag, input logic [31:0] s, f, b);
    chk({tag, "_stall"}, stall_cnt, s);
    chk({tag, "_flush"}, flush_cnt, f);
    chk({tag, "_bubble"}, bubble_cnt, b);
  endtask
  initial begin
    idle();
    chk("rst_ctl", 32'(ctl), 32'b11100);
    cnts("rst", 0, 0, 0);
    idle();
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("hit_ctl", 32'(ctl), 32'b11100);
    end
    idle();
    cnts("hit", 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("imiss_ctl", 32'(ctl), 32'b00000);
    end
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("iresp_ctl", 32'(ctl), 32'b11100);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("imiss2_ctl", 32'(ctl), 32'b00000);
    chk("imiss_stall", stall_cnt, 4);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("iresp2_ctl", 32'(ctl), 32'b11100);
    idle();
    cnts("imiss", 5, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("split_iresp_ctl", 32'(ctl), 32'b00000);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("split_c3_ctl", 32'(ctl), 32'b00000);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0, 0, 0);
    chk("split_adv_ctl", 32'(ctl), 32'b11100);
    idle();
    cnts("split", 10, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0, 0, 0);
    chk("stray_ctl", 32'(ctl), 32'b00000);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("stray_adv_ctl", 32'(ctl), 32'b11100);
    idle();
    cnts("stray", 13, 0, 0);
    step(1, 1, 1, 1, 0, 1, 5, 0, 5);
    chk("lu_rs2_ctl", 32'(ctl), 32'b00101);
    step(1, 1, 1, 1, 0, 0, 5, 0, 5);
    chk("lu_after_ctl", 32'(ctl), 32'b11100);
    chk("lu_rs2_bubble", bubble_cnt, 1);
    step(0, 0, 0, 0, 0, 1, 7, 7, 2);
    chk("lu_rs1_ctl", 32'(ctl), 32'b00101);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("lu_x0_ctl", 32'(ctl), 32'b11100);
    step(0, 0, 0, 0, 0, 1, 3, 4, 5);
    chk("lu_nomatch_ctl", 32'(ctl), 32'b11100);
    step(0, 0, 0, 0, 1, 1, 5, 0, 5);
    chk("lu_br_ctl", 32'(ctl), 32'b11110);
    idle();
    cnts("lu", 13, 1, 2);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 1, 0, 0, 0, 0);
      chk("br_dmiss_ctl", 32'(ctl), 32'b00000);
    end
    step(0, 0, 1, 1, 1, 0, 0, 0, 0);
    chk("br_dadv_ctl", 32'(ctl), 32'b11110);
    idle();
    cnts("br_dmiss", 16, 2, 2);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("mid_stall_ctl", 32'(ctl), 32'b00000);
    reset = 1'b0;
    {icache_read, icache_resp, dcache_req} = 3'b000;
    #1;
    chk("mid_rst_ctl", 32'(ctl), 32'b11100);
    cnts("mid_rst", 0, 0, 0);
    @(posedge clk); #1 reset = 1'b1;
    step(1, 0, 1, 1, 0, 0, 0, 0, 0);
    chk("post_rst_ctl", 32'(ctl), 32'b00000);
    step(1, 1, 1, 1, 0, 0, 0, 0, 0);
    idle();
    cnts("post_rst", 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central hazard and stall sequencer for the 5-stage rv32i pipeline.
- Drives the load and flush/bubble controls of the PC, IR and control-word pipeline shift registers.
- Sources of control: split I/D cache handshakes, EX-stage taken branches, and ID-stage load-use hazards.
- Keeps stall, flush and bubble event counters for performance debug.

Parameters:
CNT_W, 32, width of each performance counter.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset; all state is cleared while low.
icache_read  input  1  instruction fetch request active this cycle.
icache_resp  input  1  I-cache response, one-cycle pulse.
dcache_req  input  1  MEM stage has a load or store in flight.
dcache_resp  input  1  D-cache response, one-cycle pulse.
br_taken  input  1  EX stage resolved a taken branch or jump.
ex_is_load  input  1  instruction in ID/EX is a load.
ex_rd  input  5  destination register of ID/EX.
id_rs1  input  5  rs1 of IF/ID.
id_rs2  input  5  rs2 of IF/ID.
load_pc  output  1  PC register load enable.
load_if_id  output  1  IF/ID slot load enable.
load_back  output  1  shift enable for ID/EX, EX/MEM and MEM/WB slots.
flush_if_id  output  1  write NOP into IF/ID and ID/EX on this advance.
bubble_id_ex  output  1  write a zero control word and NOP IR into ID/EX.
stall_cnt  output  CNT_W  cycles lost to memory stalls.
flush_cnt  output  CNT_W  branch flushes taken.
bubble_cnt  output  CNT_W  load-use bubbles inserted.

Behaviour:
- Reset: state = RUN; i_done = d_done = 0; all counters = 0.
- Outputs are combinational from state and inputs. With no hazard: load_pc = load_if_id = load_back = 1, flush and bubble = 0.
- i_ok = !icache_read | icache_resp | i_done.
- d_ok = !dcache_req | dcache_resp | d_done.
- advance = i_ok & d_ok.
- FSM states:
  - RUN: if !advance, go to MEM_STALL. Latch i_done <= icache_resp and d_done <= dcache_resp, since a response can arrive in the same cycle the other side misses.
  - MEM_STALL: each cycle, OR newly arrived responses into i_done/d_done. When advance = 1, go to RUN and clear both done flags in the same edge.
- Memory stall (advance = 0), highest priority:
  - All loads = 0; flush and bubble = 0.
  - stall_cnt += 1 each stalled cycle.
  - br_taken and load-use are ignored. EX and ID hold, so both conditions re-evaluate on the advancing cycle.
- Branch flush (advance = 1 & br_taken):
  - All loads = 1, flush_if_id = 1, bubble_id_ex = 0.
  - flush_cnt += 1.
  - Overrides load-use, because the ID instruction is squashed anyway.
- Load-use (advance = 1 & !br_taken & ex_is_load & ex_rd != 0 & (ex_rd == id_rs1 | ex_rd == id_rs2)):
  - load_pc = 0, load_if_id = 0, load_back = 1, bubble_id_ex = 1.
  - bubble_cnt += 1.
  - Exactly one bubble per hazard: the next cycle ID/EX holds the bubble (ex_is_load = 0), so the hazard clears.
- x0 never creates a hazard.
- Counters wrap modulo 2^CNT_W; no saturation.
- At most one counter increments per cycle.
- Reset mid-stall: returns to RUN immediately and discards latched done flags. Caches are reset by the same signal.
- No request/response ordering is assumed between I and D sides. A stray response while the corresponding request is low is ignored and not latched.

Test Plan:
- Reset low for 2 cycles, then high with icache_read = 1 and icache_resp = 1 every cycle → all loads = 1 each cycle; all counters stay 0.
- icache_read = 1, icache_resp pulses 4 cycles after request → 4 stall cycles with loads = 0; advance on the resp cycle; stall_cnt = 4; state back to RUN.
- I-resp at cycle 2, D-resp at cycle 5 of the same stall → i_done holds from cycle 3. Advance happens only at cycle 5; stall_cnt = 5.
- ex_is_load = 1, ex_rd = 5, id_rs2 = 5, caches hit → one cycle of load_pc = 0, load_if_id = 0, bubble_id_ex = 1; bubble_cnt = 1. The next cycle, with ex_is_load = 0, runs normally.
- Load-use with ex_rd = 0 → no bubble. Load-use together with br_taken → flush_if_id = 1, bubble_id_ex = 0; flush_cnt = 1, bubble_cnt = 0.
- br_taken = 1 during a D-cache miss of 3 cycles → no flush during the stall; flush_if_id = 1 only on the advancing cycle; flush_cnt = 1.
- Reset asserted mid-stall → outputs return to reset values, counters are cleared, and no flag is latched after release.
